ps2_scancode_rx: RTL and testbench

Parametrised PS/2 device-to-host receiver for the 50 MHz domain. It synchronises and deglitches the PS/2 clock and data lines, then deframes 11-bit frames with parity and stop checking and an inter-edge timeout. It folds E0/F0 prefix bytes into single key events and buffers those events in a ready/valid FIFO. It is the front end between the keyboard connector and the key-event consumers.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_event_fifo.sv | 61 ++++++
 rtl/ps2_scancode_rx.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
// Holds the frame FSM encoding, the prefix byte values and the event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic show-ahead synchronous FIFO with an occupancy level and a drop flag.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign pop     = valid && pop_ready;
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && !push_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: input conditioning, 11-bit deframing with timeout,
// E0/F0 prefix folding and a ready/valid event FIFO.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILTER_LEN = 5,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_50,
  input  logic                          areset,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_timeout,
  output logic                          err_overflow
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [7:0]    filt_cnt;
  logic          fall_edge;
  ps2_state_t    state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          stop_edge, good_c, frame_bad_c, parity_bad_c;
  logic          byte_stb;
  logic [7:0]    byte_q;
  logic          ext_pend, brk_pend;
  logic          push_q;
  ps2_evt_t      push_evt, head_evt;

  // Idle PS/2 lines are high, so the synchronisers reset to 1.
  always_ff @(posedge clk_50 or posedge areset) begin
    if (areset) begin
      {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'b1111;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge clk_50 or posedge areset) begin
    if (areset) begin
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      fall_edge <= 1'b0;
    end else begin
      fall_edge <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
        clk_filt  <= clk_s2;
        filt_cnt  <= '0;
        fall_edge <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  assign timeout_hit = (state != ST_IDLE) && !fall_edge && (to_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk_50 or posedge areset) begin
    if (areset)                               to_cnt <= '0;
    else if (fall_edge || state == ST_IDLE)   to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYC))      to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk_50 or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = ST_IDLE;
    end else if (fall_edge) begin
      case (state)
        ST_IDLE:   if (!dat_s2) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stop-bit failure wins over parity failure.
  always_comb begin
    stop_edge    = fall_edge && (state == ST_STOP);
    frame_bad_c  = stop_edge && !dat_s2;
    parity_bad_c = stop_edge && dat_s2 && !(^{shreg, par_bit});
    good_c       = stop_edge && dat_s2 && (^{shreg, par_bit});
    busy         = (state != ST_IDLE);
  end

  always_ff @(posedge clk_50 or posedge areset) begin
    if (areset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (timeout_hit) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (fall_edge) begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          shreg   <= '0;
        end
        ST_DATA: begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        ST_PARITY: par_bit <= dat_s2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50 or posedge areset) begin
    if (areset) begin
      byte_stb    <= 1'b0;
      byte_q      <= '0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      byte_stb    <= good_c;
      err_frame   <= frame_bad_c;
      err_parity  <= parity_bad_c;
      err_timeout <= timeout_hit;
      if (good_c) byte_q <= shreg;
    end
  end

  // Prefix bytes only arm flags; any other byte becomes one event.
  always_ff @(posedge clk_50 or posedge areset) begin
    if (areset) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      push_q   <= 1'b0;
      push_evt <= '0;
    end else begin
      push_q <= 1'b0;
      if (err_frame || err_parity || err_timeout) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_stb) begin
        if (byte_q == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (byte_q == PS2_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          push_q   <= 1'b1;
          push_evt <= '{ext: ext_pend, brk: brk_pend, code: byte_q};
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH($bits(ps2_evt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_50),
    .rst       (areset),
    .push      (push_q),
    .push_data (push_evt),
    .pop_ready (evt_ready),
    .valid     (evt_valid),
    .head      (head_evt),
    .level     (fifo_level),
    .overflow  (err_overflow)
  );

  assign evt_code = head_evt.code;
  assign evt_ext  = head_evt.ext;
  assign evt_brk  = head_evt.brk;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: scenario tasks plus a randomized run
// compared against a byte-level prefix/FIFO model.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 5;
  localparam int FIFO_DEPTH = 8;
  localparam int HALF       = 20;
  localparam int LAT_VALID  = 2 + FILTER_LEN + 3;

  logic       clk_50 = 1'b0;
  logic       areset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_ext, evt_brk, busy;
  logic [7:0] evt_code;
  logic [3:0] fifo_level;
  logic       err_parity, err_frame, err_timeout, err_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  bit m_ext = 1'b0, m_brk = 1'b0;
  bit rand_ready = 1'b0;

  // Notional 1 MHz clock: one cycle per microsecond keeps frames short.
  ps2_scancode_rx #(
    .CLK_HZ(1_000_000), .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(200), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_50(clk_50), .areset(areset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .fifo_level(fifo_level), .busy(busy),
    .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout),
    .err_overflow(err_overflow)
  );

  always #5 clk_50 = ~clk_50;

  always @(negedge clk_50) begin
    if (err_parity)   n_par++;
    if (err_frame)    n_frm++;
    if (err_timeout)  n_to++;
    if (err_overflow) n_ovf++;
    if (evt_valid && evt_ready) got_q.push_back({evt_ext, evt_brk, evt_code});
  end

  always @(posedge clk_50) begin
    if (rand_ready) begin
      #1;
      evt_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    ps2_dat = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = frame_bits(b, bad_par, bad_stop);
    for (int i = 0; i < nbits; i++) send_bit(bits[i]);
    ps2_dat = 1'b1;
    tick(2 * HALF);
  endtask

  // Byte-level reference: prefixes arm flags, errors clear them, others emit.
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic test_reset;
    tick(3);
    n_tests++;
    if ({evt_valid, evt_code, evt_ext, evt_brk, fifo_level, busy, err_parity, err_frame,
         err_timeout, err_overflow} !== 20'd0) begin
      $display("[TB] FAIL reset_outputs: got busy=%b valid=%b level=%0d, expected all 0", busy, evt_valid, fifo_level);
      n_fail++;
    end
    areset = 1'b0;
    tick(10);
    n_tests++;
    if ({evt_valid, busy, fifo_level} !== 6'd0) begin
      $display("[TB] FAIL after_reset: got valid=%b busy=%b level=%0d, expected 0", evt_valid, busy, fifo_level);
      n_fail++;
    end
  endtask

  task automatic test_good_frame;
    logic [10:0] bits;
    int lat;
    evt_ready = 1'b0;
    bits = frame_bits(8'h1C, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    ps2_dat = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (evt_valid) begin lat = k; break; end
    end
    tick(5);
    ps2_clk = 1'b1;
    tick(HALF);
    n_tests++;
    if (lat !== LAT_VALID) begin
      $display("[TB] FAIL good_latency: got %0d cycles, expected %0d", lat, LAT_VALID);
      n_fail++;
    end
    n_tests++;
    if (fifo_level !== 4'd1) begin
      $display("[TB] FAIL good_level: got %0d, expected 1", fifo_level);
      n_fail++;
    end
    n_tests++;
    if ({evt_ext, evt_brk, evt_code} !== 10'h01C) begin
      $display("[TB] FAIL good_event: got %h, expected 01c", {evt_ext, evt_brk, evt_code});
      n_fail++;
    end
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    n_tests++;
    if ({evt_valid, fifo_level} !== 5'd0) begin
      $display("[TB] FAIL good_pop: got valid=%b level=%0d, expected 0/0", evt_valid, fifo_level);
      n_fail++;
    end
  endtask

  task automatic test_prefixed;
    logic [7:0] seq [4] = '{8'hE0, 8'hF0, 8'h75, 8'h1C};
    logic [9:0] act;
    got_q.delete(); exp_q.delete();
    evt_ready = 1'b1;
    foreach (seq[i]) begin
      send_frame(seq[i], 1'b0, 1'b0, 11);
      model_byte(seq[i], 1'b1);
    end
    tick(10);
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      $display("[TB] FAIL prefix_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < got_q.size()) ? got_q[i] : 10'bx;
      n_tests++;
      if (act !== exp_q[i]) begin
        $display("[TB] FAIL prefix_event%0d: got %h, expected %h", i, act, exp_q[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_errors;
    int p0, f0;
    logic [9:0] act;
    got_q.delete(); exp_q.delete();
    evt_ready = 1'b1;
    p0 = n_par; f0 = n_frm;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    model_byte(8'h1C, 1'b0);
    n_tests++;
    if ({n_par - p0, n_frm - f0, got_q.size()} !== {32'd1, 32'd0, 32'd0}) begin
      $display("[TB] FAIL parity_err: got par=%0d frm=%0d ev=%0d, expected 1/0/0", n_par - p0, n_frm - f0, got_q.size());
      n_fail++;
    end
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    model_byte(8'h1C, 1'b0);
    n_tests++;
    if ({n_par - p0, n_frm - f0, got_q.size()} !== {32'd1, 32'd1, 32'd0}) begin
      $display("[TB] FAIL frame_err: got par=%0d frm=%0d ev=%0d, expected 1/1/0", n_par - p0, n_frm - f0, got_q.size());
      n_fail++;
    end
    send_frame(8'hF0, 1'b0, 1'b0, 11); model_byte(8'hF0, 1'b1);
    send_frame(8'h33, 1'b1, 1'b0, 11); model_byte(8'h33, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 11); model_byte(8'h1C, 1'b1);
    tick(10);
    act = (got_q.size() == 1) ? got_q[0] : 10'bx;
    n_tests++;
    if (act !== exp_q[0]) begin
      $display("[TB] FAIL err_clears_prefix: got %h (n=%0d), expected %h", act, got_q.size(), exp_q[0]);
      n_fail++;
    end
  endtask

  task automatic test_timeout;
    int t0;
    logic [9:0] act;
    got_q.delete(); exp_q.delete();
    evt_ready = 1'b1;
    t0 = n_to;
    send_frame(8'hE0, 1'b0, 1'b0, 11); model_byte(8'hE0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b0, 5);
    n_tests++;
    if (busy !== 1'b1) begin
      $display("[TB] FAIL busy_mid_frame: got %b, expected 1", busy);
      n_fail++;
    end
    tick(250);
    model_byte(8'h00, 1'b0);
    n_tests++;
    if ({n_to - t0, 31'd0, busy} !== {32'd1, 32'd0}) begin
      $display("[TB] FAIL timeout: got pulses=%0d busy=%b, expected 1/0", n_to - t0, busy);
      n_fail++;
    end
    send_frame(8'h29, 1'b0, 1'b0, 11); model_byte(8'h29, 1'b1);
    tick(10);
    act = (got_q.size() == 1) ? got_q[0] : 10'bx;
    n_tests++;
    if (act !== exp_q[0]) begin
      $display("[TB] FAIL after_timeout: got %h (n=%0d), expected %h", act, got_q.size(), exp_q[0]);
      n_fail++;
    end
  endtask

  task automatic test_overflow;
    int o0, drops;
    logic [10:0] bits;
    logic [9:0] act;
    got_q.delete(); exp_q.delete();
    evt_ready = 1'b0;
    o0 = n_ovf; drops = 0;
    for (int c = 1; c <= 9; c++) begin
      send_frame(8'(c), 1'b0, 1'b0, 11);
      if (exp_q.size() < FIFO_DEPTH) model_byte(8'(c), 1'b1);
      else drops++;
    end
    n_tests++;
    if (fifo_level !== 4'd8) begin
      $display("[TB] FAIL full_level: got %0d, expected 8", fifo_level);
      n_fail++;
    end
    n_tests++;
    if (n_ovf - o0 !== drops) begin
      $display("[TB] FAIL overflow_pulses: got %0d, expected %0d", n_ovf - o0, drops);
      n_fail++;
    end
    // Land a single pop exactly on the cycle the 0x0A push reaches the full FIFO.
    bits = frame_bits(8'h0A, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    ps2_dat = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(LAT_VALID - 1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    tick(5);
    ps2_clk = 1'b1;
    tick(HALF);
    model_byte(8'h0A, 1'b1);
    n_tests++;
    if ({fifo_level, 28'd0, n_ovf - o0} !== {4'd8, 28'd0, drops}) begin
      $display("[TB] FAIL push_pop_full: got level=%0d ovf=%0d, expected 8/%0d", fifo_level, n_ovf - o0, drops);
      n_fail++;
    end
    evt_ready = 1'b1;
    tick(12);
    evt_ready = 1'b0;
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      $display("[TB] FAIL drain_count: got %0d, expected %0d", got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < got_q.size()) ? got_q[i] : 10'bx;
      n_tests++;
      if (act !== exp_q[i]) begin
        $display("[TB] FAIL drain%0d: got %h, expected %h", i, act, exp_q[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_glitch_reset;
    int e0, t0;
    logic [9:0] act;
    got_q.delete(); exp_q.delete();
    evt_ready = 1'b0;
    e0 = n_par + n_frm + n_to;
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(2);
    ps2_dat = 1'b1;
    tick(30);
    n_tests++;
    if ({busy, fifo_level} !== 5'd0 || (n_par + n_frm + n_to) !== e0) begin
      $display("[TB] FAIL glitch: got busy=%b level=%0d errs=%0d, expected 0/0/0", busy, fifo_level, n_par + n_frm + n_to - e0);
      n_fail++;
    end
    send_frame(8'h16, 1'b0, 1'b0, 11);
    send_frame(8'h5A, 1'b0, 1'b0, 4);
    n_tests++;
    if ({busy, fifo_level} !== {1'b1, 4'd1}) begin
      $display("[TB] FAIL pre_reset: got busy=%b level=%0d, expected 1/1", busy, fifo_level);
      n_fail++;
    end
    areset = 1'b1;
    tick(2);
    n_tests++;
    if ({evt_valid, evt_code, evt_ext, evt_brk, fifo_level, busy, err_parity, err_frame,
         err_timeout, err_overflow} !== 20'd0) begin
      $display("[TB] FAIL mid_reset: got busy=%b valid=%b level=%0d code=%h, expected all 0", busy, evt_valid, fifo_level, evt_code);
      n_fail++;
    end
    areset = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0;
    t0 = n_to;
    tick(250);
    n_tests++;
    if (n_to !== t0) begin
      $display("[TB] FAIL reset_no_timeout: got %0d pulses, expected 0", n_to - t0);
      n_fail++;
    end
    evt_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0, 11); model_byte(8'h5A, 1'b1);
    tick(10);
    act = (got_q.size() == 1) ? got_q[0] : 10'bx;
    n_tests++;
    if (act !== exp_q[0]) begin
      $display("[TB] FAIL after_reset_frame: got %h (n=%0d), expected %h", act, got_q.size(), exp_q[0]);
      n_fail++;
    end
  endtask

  task automatic test_random;
    int p0, exp_par;
    logic [7:0] b;
    bit bad;
    int r;
    logic [9:0] act;
    got_q.delete(); exp_q.delete();
    p0 = n_par; exp_par = 0;
    rand_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
      end
      bad = ($urandom_range(0, 7) == 0);
      send_frame(b, bad, 1'b0, 11);
      model_byte(b, !bad);
      if (bad) exp_par++;
    end
    rand_ready = 1'b0;
    tick(1);
    evt_ready = 1'b1;
    tick(20);
    n_tests++;
    if (n_par - p0 !== exp_par) begin
      $display("[TB] FAIL rand_parity: got %0d, expected %0d", n_par - p0, exp_par);
      n_fail++;
    end
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      $display("[TB] FAIL rand_count: got %0d, expected %0d", got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < got_q.size()) ? got_q[i] : 10'bx;
      n_tests++;
      if (act !== exp_q[i]) begin
        $display("[TB] FAIL rand_event%0d: got %h, expected %h", i, act, exp_q[i]);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_prefixed();
    test_errors();
    test_timeout();
    test_overflow();
    test_glitch_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
